// File: rtl/range_window_ctrl.sv
// Purpose: sequences one min/max range-finder window (go, samples, finish) and holds the captured range.
// Latency: result_valid rises 2 edges after the last sample transfer; a 1-sample window adds the PRIME cycle.
// Backpressure: sample_ready only in ARM/ACCUM; result is held in DONE until result_ready.
module range_window_ctrl #(
    parameter int WIDTH = 10,
    parameter int LEN_W = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_window_len,
    input  logic             i_abort,
    input  logic             i_sample_valid,
    input  logic [WIDTH-1:0] i_sample_data,
    output logic             o_sample_ready,
    output logic [WIDTH-1:0] o_rf_data,
    output logic             o_rf_go,
    output logic             o_rf_finish,
    input  logic [WIDTH-1:0] i_rf_range,
    input  logic             i_rf_error,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic [WIDTH-1:0] o_result_range,
    output logic             o_result_err,
    output logic             o_busy,
    output logic             o_cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_PRIME   = 3'd2,
        S_ACCUM   = 3'd3,
        S_FINISH  = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6,
        S_DRAIN   = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [LEN_W-1:0]   r_rem;
    logic [LEN_W-1:0]   w_next_rem;
    logic               w_load;
    logic               w_cfg_err;
    logic               w_sample_ready;
    logic               w_xfer;
    logic [WIDTH-1:0]   r_rf_data;
    logic               r_rf_go;
    logic               r_rf_finish;
    logic [WIDTH-1:0]   r_result_range;
    logic               r_result_err;
    logic               r_cfg_err;

    assign w_sample_ready = (r_state == S_ARM) || (r_state == S_ACCUM);
    assign w_xfer         = i_sample_valid && w_sample_ready;

    // Next-state, remaining-count and sample-load decode; abort beats a coincident transfer.
    always_comb begin
        w_next_state = r_state;
        w_next_rem   = r_rem;
        w_load       = 1'b0;
        w_cfg_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_window_len != '0) begin
                        w_next_rem   = i_window_len;
                        w_next_state = S_ARM;
                    end else begin
                        w_cfg_err = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (i_abort) begin
                    // Datapath never saw go, so leave without a finish pulse.
                    w_next_state = S_IDLE;
                end else if (w_xfer) begin
                    w_load       = 1'b1;
                    w_next_rem   = r_rem - LEN_W'(1);
                    w_next_state = S_PRIME;
                end
            end
            S_PRIME: begin
                w_next_state = (r_rem == '0) ? S_FINISH : S_ACCUM;
            end
            S_ACCUM: begin
                if (i_abort) begin
                    w_next_state = S_DRAIN;
                end else if (w_xfer) begin
                    w_load     = 1'b1;
                    w_next_rem = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_next_state = S_FINISH;
                    end
                end
            end
            S_FINISH:  w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_DONE;
            S_DONE: begin
                if (i_result_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            S_DRAIN:   w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // State and remaining-sample counter.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
        end else begin
            r_state <= w_next_state;
            r_rem   <= w_next_rem;
        end
    end

    // Datapath pins registered so go/finish line up exactly with PRIME and FINISH/DRAIN.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rf_data   <= '0;
            r_rf_go     <= 1'b0;
            r_rf_finish <= 1'b0;
        end else begin
            if (w_load) begin
                r_rf_data <= i_sample_data;
            end
            r_rf_go     <= (w_next_state == S_PRIME);
            r_rf_finish <= (w_next_state == S_FINISH) || (w_next_state == S_DRAIN);
        end
    end

    // Result capture one cycle after finish, plus the config-error pulse.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_result_range <= '0;
            r_result_err   <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            if (r_state == S_CAPTURE) begin
                r_result_range <= i_rf_range;
                r_result_err   <= i_rf_error;
            end
            r_cfg_err <= w_cfg_err;
        end
    end

    assign o_sample_ready = w_sample_ready;
    assign o_rf_data      = r_rf_data;
    assign o_rf_go        = r_rf_go;
    assign o_rf_finish    = r_rf_finish;
    assign o_result_valid = (r_state == S_DONE);
    assign o_result_range = r_result_range;
    assign o_result_err   = r_result_err;
    assign o_busy         = (r_state != S_IDLE);
    assign o_cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_range_window_ctrl.sv
// Purpose: directed and random windows against a behavioural range-finder and a max-min reference.
// Latency: checks result timing relative to the last transfer edge.
// Backpressure: exercises sample gaps and held results with result_ready low.
module tb_range_window_ctrl;

    localparam int WIDTH = 10;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] window_len = '0;
    logic             abort = 1'b0;
    logic             sample_valid = 1'b0;
    logic [WIDTH-1:0] sample_data = '0;
    logic             sample_ready;
    logic [WIDTH-1:0] rf_data;
    logic             rf_go;
    logic             rf_finish;
    logic [WIDTH-1:0] rf_range;
    logic             rf_error;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic [WIDTH-1:0] result_range;
    logic             result_err;
    logic             busy;
    logic             cfg_err;

    int checks = 0;
    int errors = 0;
    int smp[$];

    // behavioural range-finder datapath
    logic [WIDTH-1:0] dp_min = '0;
    logic [WIDTH-1:0] dp_max = '0;
    logic [WIDTH-1:0] dp_range = '0;
    logic             dp_active = 1'b0;
    logic             dp_err = 1'b0;
    logic             err_inj = 1'b0;
    logic             inv_viol = 1'b0;

    always #5 clk = ~clk;

    range_window_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_start        (start),
        .i_window_len   (window_len),
        .i_abort        (abort),
        .i_sample_valid (sample_valid),
        .i_sample_data  (sample_data),
        .o_sample_ready (sample_ready),
        .o_rf_data      (rf_data),
        .o_rf_go        (rf_go),
        .o_rf_finish    (rf_finish),
        .i_rf_range     (rf_range),
        .i_rf_error     (rf_error),
        .o_result_valid (result_valid),
        .i_result_ready (result_ready),
        .o_result_range (result_range),
        .o_result_err   (result_err),
        .o_busy         (busy),
        .o_cfg_err      (cfg_err)
    );

    assign rf_range = dp_range;
    assign rf_error = dp_err | err_inj;

    // Datapath: go loads data as min/max, later edges fold data in, finish publishes max-min.
    always @(posedge clk) begin : dp_model
        logic [WIDTH-1:0] nmn;
        logic [WIDTH-1:0] nmx;
        nmn = (rf_data < dp_min) ? rf_data : dp_min;
        nmx = (rf_data > dp_max) ? rf_data : dp_max;
        if (rf_go && rf_finish) begin
            dp_err <= 1'b1;
        end else if (rf_go) begin
            dp_active <= 1'b1;
            dp_min    <= rf_data;
            dp_max    <= rf_data;
        end else if (dp_active) begin
            dp_min <= nmn;
            dp_max <= nmx;
            if (rf_finish) begin
                dp_active <= 1'b0;
                dp_range  <= nmx - nmn;
            end
        end else if (rf_finish) begin
            dp_err <= 1'b1;
        end
    end

    // Sticky record of go and finish ever being high together.
    always @(negedge clk) begin
        if (rf_go && rf_finish) inv_viol <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input string tag, input int data);
        int budget;
        sample_valid = 1'b1;
        sample_data  = WIDTH'(data);
        budget = 0;
        while (!sample_ready && budget < 10) begin
            tick();
            budget++;
        end
        check({tag, "_ready"}, sample_ready, 1);
        tick();
        sample_valid = 1'b0;
        check({tag, "_rf_data"}, rf_data, data);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, sample_ready, 0);
        check({tag, "_rf_data"}, rf_data, 0);
        check({tag, "_go"}, rf_go, 0);
        check({tag, "_finish"}, rf_finish, 0);
        check({tag, "_rvalid"}, result_valid, 0);
        check({tag, "_rrange"}, result_range, 0);
        check({tag, "_rerr"}, result_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
    endtask

    // Runs one window over smp[]; expected range is max-min of the queue.
    task automatic run_window(input string tag, input int gap_min, input int gap_max,
                              input int hold, input logic err_exp);
        int len;
        int mn;
        int mx;
        int lat;
        logic [WIDTH-1:0] held;
        len = smp.size();
        mn = smp[0];
        mx = smp[0];
        foreach (smp[i]) begin
            if (smp[i] < mn) mn = smp[i];
            if (smp[i] > mx) mx = smp[i];
        end
        result_ready = 1'b0;
        start = 1'b1;
        window_len = LEN_W'(len);
        tick();
        start = 1'b0;
        check({tag, "_busy"}, busy, 1);
        for (int i = 0; i < len; i++) begin
            repeat (int'($urandom_range(gap_max, gap_min))) tick();
            send_sample(tag, smp[i]);
            if (i == 0) begin
                check({tag, "_prime_go"}, rf_go, 1);
                check({tag, "_prime_fin"}, rf_finish, 0);
                check({tag, "_prime_ready"}, sample_ready, 0);
            end
        end
        if (len == 1) tick();
        check({tag, "_finish_go"}, rf_go, 0);
        check({tag, "_finish"}, rf_finish, 1);
        lat = 0;
        while (!result_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        check({tag, "_range"}, result_range, mx - mn);
        check({tag, "_err"}, result_err, err_exp);
        check({tag, "_done_ready"}, sample_ready, 0);
        held = result_range;
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_valid"}, result_valid, 1);
            check({tag, "_hold_range"}, result_range, held);
            check({tag, "_hold_ready"}, sample_ready, 0);
        end
        result_ready = 1'b1;
        start = 1'b1;
        window_len = 3;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        check({tag, "_ack_valid"}, result_valid, 0);
        check({tag, "_ack_idle"}, busy, 0);
    endtask

    initial begin
        logic seen;
        #1 rst_n = 1'b0;
        #2;
        check_reset_outputs("por_async");
        tick();
        tick();
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // basic window
        smp = '{7, 3, 9, 5};
        run_window("basic", 0, 0, 0, 1'b0);

        // single sample
        smp = '{200};
        run_window("single", 0, 0, 1, 1'b0);

        // gaps and held result
        smp = '{100, 1023, 0};
        run_window("gaps", 5, 5, 10, 1'b0);

        // abort in ACCUM after two samples, coincident with a transfer
        start = 1'b1;
        window_len = 5;
        tick();
        start = 1'b0;
        send_sample("abort", 20);
        send_sample("abort", 50);
        abort = 1'b1;
        sample_valid = 1'b1;
        sample_data = 1000;
        tick();
        abort = 1'b0;
        sample_valid = 1'b0;
        check("abort_drain_fin", rf_finish, 1);
        check("abort_drain_go", rf_go, 0);
        check("abort_discard", rf_data, 50);
        check("abort_drain_valid", result_valid, 0);
        tick();
        check("abort_idle", busy, 0);
        check("abort_fin_drop", rf_finish, 0);
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (result_valid) seen = 1'b1;
        end
        check("abort_no_result", seen, 0);
        smp = '{10, 4};
        run_window("after_abort", 0, 1, 0, 1'b0);

        // abort in ARM: no finish at all
        start = 1'b1;
        window_len = 3;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("arm_abort_idle", busy, 0);
        check("arm_abort_fin", rf_finish, 0);
        tick();
        check("arm_abort_fin2", rf_finish, 0);

        // zero-length start
        start = 1'b1;
        window_len = 0;
        tick();
        start = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        tick();
        check("cfg_err_drop", cfg_err, 0);
        check("cfg_err_busy2", busy, 0);

        // datapath error propagates to result_err
        err_inj = 1'b1;
        smp = '{300, 310, 290};
        run_window("err_inj", 0, 1, 0, 1'b1);
        err_inj = 1'b0;

        // random windows
        for (int w = 0; w < 12; w++) begin
            int len;
            len = int'($urandom_range(8, 1));
            smp.delete();
            for (int k = 0; k < len; k++) smp.push_back(int'($urandom_range(1023, 0)));
            run_window("rand", 0, 2, int'($urandom_range(2, 0)), 1'b0);
        end

        // async reset in ACCUM
        start = 1'b1;
        window_len = 5;
        tick();
        start = 1'b0;
        send_sample("rst", 77);
        send_sample("rst", 88);
        check("rst_in_accum", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", busy, 0);

        check("go_fin_exclusive", inv_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
